truth_table_sweeper: RTL and testbench
======================================

// Module: truth_table_sweeper
// PURPOSE
//   Sequential successor to the single-function combinational truth-table testers.
//   Holds a programmable N_IN-input boolean function as a 2**N_IN-bit truth-table register.
//   On start, sweeps every input row 0..2**N_IN-1 in order and emits (row, s) over a valid/ready stream.
//   Counts minterms (rows with s=1) and flags completion.
//   Intended as a self-test / table-dump engine feeding a monitor or UART-style consumer.
// PARAMETERS
//   N_IN   3   number of function inputs, legal range 1..6; row bit N_IN-1 = x (MSB), bit 0 = last input
// PORTS
//   clk        in   1            rising-edge clock
//   reset      in   1            synchronous, active-high reset
//   tt_load    in   1            load tt_data into truth-table register (IDLE/DONE only)
//   tt_data    in   2**N_IN      truth table; bit r = f(row r)
//   start      in   1            begin sweep (IDLE/DONE only)
//   abort      in   1            cancel sweep, return to IDLE
//   out_valid  out  1            out_row/out_s valid
//   out_ready  in   1            consumer accepts when high with out_valid
//   out_row    out  N_IN         current input combination
//   out_s      out  1            tt_reg[out_row]
//   busy       out  1            high in RUN
//   done       out  1            sticky: sweep completed; cleared by start/abort/reset
//   ones_cnt   out  N_IN+1       count of accepted rows with out_s=1
// BEHAVIOUR
//   Clock/reset: one clock clk; reset is synchronous and active-high, sampled on rising edge of clk.
//   Reset: state=IDLE, tt_reg=0, out_row=0, out_valid=0, busy=0, done=0, ones_cnt=0; out_s=tt_reg[0]=0.
//   FSM: IDLE -start-> RUN; RUN -last row accepted-> DONE; DONE -start-> RUN; RUN -abort-> IDLE; DONE -abort-> IDLE.
//   tt_load: honoured in IDLE/DONE; ignored in RUN.
//     With start in the same cycle, load wins first and row 0 uses the new table.
//   start (IDLE/DONE) at edge t:
//     out_row=0, ones_cnt=0, done=0, busy=1, out_valid=1 from t+1.
//     Latency start->first valid = 1 cycle.
//   start in RUN: ignored.
//   out_s is combinational from tt_reg[out_row]; out_row/out_s stable while out_valid & !out_ready.
//   Transfer = out_valid & out_ready at an edge:
//     ones_cnt += out_s.
//     If out_row == 2**N_IN-1: next state DONE, out_valid=0, busy=0, done=1; out_row holds last value.
//     Otherwise out_row+1, out_valid stays 1 (one row per cycle at full throughput).
//   ones_cnt: N_IN+1 bits, max 2**N_IN, no overflow possible; holds after DONE until next start.
//   abort: highest priority after reset.
//     Any state -> IDLE, out_valid=0, busy=0, done=0; tt_reg and ones_cnt hold.
//     abort and start in the same cycle: abort wins.
//   Reset mid-sweep: immediate return to reset values, tt_reg cleared.
// CONFIGURATION
//   TT_SIG_EN defined: adds output sig [7:0].
//     Cleared to 0 on reset and start.
//     On each transfer: sig <= {sig[6:0], sig[7]^out_s}; holds after DONE.
//   TT_SIG_EN undefined: no sig port, no signature logic.
// TESTING (N_IN=3 unless noted)
//   1. Reset asserted 2 cycles -> out_valid=0, busy=0, done=0, ones_cnt=0, out_row=0.
//   2. tt_load tt_data=8'hDC, then start, out_ready=1 ->
//      rows 0..7 on consecutive cycles, out_s=0,0,1,1,1,0,1,1;
//      done=1 one cycle after row 7, ones_cnt=5.
//   3. As 2, out_ready=0 for 4 cycles while out_row=3 ->
//      out_row=3, out_s=1 held, ones_cnt unchanged; resumes at row 4.
//   4. start pulsed at row 2 -> ignored; abort at row 5 -> IDLE, out_valid=0, done=0, tt_reg=8'hDC kept.
//   5. tt_load 8'hFF + start same cycle -> all out_s=1, ones_cnt=8;
//      reset at row 4 -> all reset values, tt_reg=0.
//   6. TT_SIG_EN, table 8'hDC full sweep -> sig=8'h3B;
//      N_IN=1, tt=2'b10 -> rows 0,1, out_s=0,1, ones_cnt=1.

Source files
------------

// File: rtl/truth_table_sweeper.sv
// rtl/truth_table_sweeper.sv - sweeps a programmable N_IN-input truth table over a valid/ready stream
// Optional TT_SIG_EN macro adds an 8-bit running signature output (sig).
module truth_table_sweeper #(
  parameter int N_IN = 3
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   tt_load,
  input  logic [(1<<N_IN)-1:0]   tt_data,
  input  logic                   start,
  input  logic                   abort,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [N_IN-1:0]        out_row,
  output logic                   out_s,
  output logic                   busy,
  output logic                   done,
`ifdef TT_SIG_EN
  output logic [N_IN:0]          ones_cnt,
  output logic [7:0]             sig
`else
  output logic [N_IN:0]          ones_cnt
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  localparam logic [N_IN-1:0] LAST_ROW = {N_IN{1'b1}};

  state_t                state_q, state_d;
  logic [(1<<N_IN)-1:0]  tt_reg;
  logic                  xfer;
  logic                  last_row;
  logic                  start_ok;
  logic                  load_ok;

  assign out_valid = (state_q == S_RUN);
  assign busy      = (state_q == S_RUN);
  assign done      = (state_q == S_DONE);
  assign out_s     = tt_reg[out_row];
  assign last_row  = (out_row == LAST_ROW);

  // abort outranks every other request, including a transfer on the same edge
  assign xfer     = out_valid & out_ready & ~abort;
  assign start_ok = start   & ~abort & (state_q != S_RUN);
  assign load_ok  = tt_load & ~abort & (state_q != S_RUN);

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_RUN;
      S_RUN:   if (xfer && last_row) state_d = S_DONE;
      S_DONE:  if (start) state_d = S_RUN;
      default: state_d = S_IDLE;
    endcase
    if (abort) state_d = S_IDLE;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      tt_reg   <= '0;
      out_row  <= '0;
      ones_cnt <= '0;
`ifdef TT_SIG_EN
      sig      <= '0;
`endif
    end else begin
      state_q <= state_d;
      if (load_ok) tt_reg <= tt_data;
      if (start_ok) begin
        out_row  <= '0;
        ones_cnt <= '0;
`ifdef TT_SIG_EN
        sig      <= '0;
`endif
      end else if (xfer) begin
        ones_cnt <= ones_cnt + {{N_IN{1'b0}}, out_s};
`ifdef TT_SIG_EN
        sig      <= {sig[6:0], sig[7] ^ out_s};
`endif
        // the final row stays on out_row after the sweep completes
        if (!last_row) out_row <= out_row + N_IN'(1);
      end
    end
  end

endmodule

// File: tb/tb_truth_table_sweeper.sv
// tb/tb_truth_table_sweeper.sv - self-checking bench for truth_table_sweeper
// Vector table plus scoreboard of expected (row, s) transfers; TT_SIG_EN also checks sig.
module tb_truth_table_sweeper;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset = 1'b1;
  logic       tt_load = 1'b0;
  logic [7:0] tt_data = '0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic [2:0] out_row;
  logic       out_s;
  logic       busy;
  logic       done;
  logic [3:0] ones_cnt;
`ifdef TT_SIG_EN
  logic [7:0] sig;
  logic [7:0] b_sig;
`endif

  logic       b_tt_load = 1'b0;
  logic [1:0] b_tt_data = '0;
  logic       b_start = 1'b0;
  logic       b_out_valid;
  logic [0:0] b_out_row;
  logic       b_out_s;
  logic       b_busy;
  logic       b_done;
  logic [1:0] b_ones_cnt;

  truth_table_sweeper #(.N_IN(3)) dut (
    .clk(clk), .reset(reset), .tt_load(tt_load), .tt_data(tt_data),
    .start(start), .abort(abort), .out_valid(out_valid), .out_ready(out_ready),
    .out_row(out_row), .out_s(out_s), .busy(busy), .done(done),
`ifdef TT_SIG_EN
    .ones_cnt(ones_cnt), .sig(sig)
`else
    .ones_cnt(ones_cnt)
`endif
  );

  truth_table_sweeper #(.N_IN(1)) dut1 (
    .clk(clk), .reset(reset), .tt_load(b_tt_load), .tt_data(b_tt_data),
    .start(b_start), .abort(1'b0), .out_valid(b_out_valid), .out_ready(1'b1),
    .out_row(b_out_row), .out_s(b_out_s), .busy(b_busy), .done(b_done),
`ifdef TT_SIG_EN
    .ones_cnt(b_ones_cnt), .sig(b_sig)
`else
    .ones_cnt(b_ones_cnt)
`endif
  );

  typedef struct { logic [7:0] tt; int ones; } vec_t;
  typedef struct { logic [2:0] row; logic s; } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_table(input logic [7:0] tt);
    for (int r = 0; r < 8; r++) begin
      exp_t e;
      e.row = 3'(r);
      e.s   = tt[r];
      sb.push_back(e);
    end
  endtask

  // drives start (optionally with a load) for one edge; returns just after that edge
  task automatic start_sweep(input logic [7:0] tt, input logic with_load);
    tick();
    tt_load = with_load;
    tt_data = tt;
    start   = 1'b1;
    push_table(tt);
    tick();
    tt_load = 1'b0;
    start   = 1'b0;
  endtask

  task automatic wait_done(input int budget, output int cycles);
    cycles = 0;
    while (cycles < budget) begin
      @(negedge clk);
      cycles++;
      if (done) break;
    end
    check("done_reached", done, 1);
  endtask

  // scoreboard: every accepted transfer must match the next expected row
  always @(negedge clk) begin
    if (!reset && !abort && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL sb_empty: unexpected transfer row %0d s %0d", out_row, out_s);
      end else begin
        mon_e = sb.pop_front();
        check("sb_row", out_row, mon_e.row);
        check("sb_s", out_s, mon_e.s);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, got running expected finished");
    $fatal(1);
  end

  vec_t vecs[6];
  int   cyc;
  int   stalls;

  initial begin
    vecs[0] = '{8'hDC, 5};
    vecs[1] = '{8'hFF, 8};
    vecs[2] = '{8'h00, 0};
    vecs[3] = '{8'h01, 1};
    vecs[4] = '{8'h80, 1};
    vecs[5] = '{8'hA5, 4};

    // reset held two cycles
    tick();
    tick();
    @(negedge clk);
    check("rst_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_ones", ones_cnt, 0);
    check("rst_row", out_row, 0);
    check("rst_s", out_s, 0);
    reset = 1'b0;

    // load alone, then start; first valid one cycle after start
    tick();
    tt_load = 1'b1;
    tt_data = 8'hDC;
    tick();
    tt_load = 1'b0;
    start_sweep(8'hDC, 1'b0);
    @(negedge clk);
    check("first_valid", out_valid, 1);
    check("first_busy", busy, 1);
    check("first_row", out_row, 0);
    check("first_done", done, 0);
    wait_done(40, cyc);
    check("dc_cycles", cyc, 8);
    check("dc_ones", ones_cnt, 5);
`ifdef TT_SIG_EN
    check("dc_sig", sig, 8'h3B);
`endif

    // table of load+start sweeps at full throughput
    for (int i = 0; i < 6; i++) begin
      start_sweep(vecs[i].tt, 1'b1);
      wait_done(40, cyc);
      check("vec_cycles", cyc, 9);
      check("vec_ones", ones_cnt, vecs[i].ones);
      check("vec_busy", busy, 0);
      check("vec_valid", out_valid, 0);
      check("vec_row_hold", out_row, 7);
      check("vec_sb_empty", sb.size(), 0);
      tick();
      @(negedge clk);
      check("vec_done_sticky", done, 1);
      check("vec_ones_hold", ones_cnt, vecs[i].ones);
    end

    // backpressure: hold row 3 for 4 cycles
    start_sweep(8'hDC, 1'b1);
    stalls = 0;
    for (int c = 0; c < 60 && !done; c++) begin
      if (out_valid && out_row == 3 && stalls < 4) begin
        out_ready = 1'b0;
        stalls++;
      end else begin
        out_ready = 1'b1;
      end
      @(negedge clk);
      if (!out_ready) begin
        check("stall_row", out_row, 3);
        check("stall_s", out_s, 1);
        check("stall_ones", ones_cnt, 1);
      end
      tick();
    end
    out_ready = 1'b1;
    check("stall_count", stalls, 4);
    check("stall_done", done, 1);
    check("stall_ones_final", ones_cnt, 5);
    check("stall_sb_empty", sb.size(), 0);

    // start and load ignored mid-run; abort at row 5
    start_sweep(8'hDC, 1'b1);
    for (int c = 0; c < 30; c++) begin
      start   = (out_row == 3'd2);
      tt_load = (out_row == 3'd3);
      tt_data = 8'h00;
      if (out_row == 3'd5) begin
        abort = 1'b1;
        tick();
        abort = 1'b0;
        break;
      end
      tick();
    end
    start   = 1'b0;
    tt_load = 1'b0;
    @(negedge clk);
    check("abort_valid", out_valid, 0);
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_ones", ones_cnt, 3);
    check("abort_sb_left", sb.size(), 3);
    sb.delete();
    start_sweep(8'hDC, 1'b0);
    wait_done(40, cyc);
    check("kept_tt_ones", ones_cnt, 5);

    // abort and start together from DONE: abort wins
    tick();
    abort = 1'b1;
    start = 1'b1;
    tick();
    abort = 1'b0;
    start = 1'b0;
    @(negedge clk);
    check("abst_done", done, 0);
    check("abst_busy", busy, 0);
    check("abst_valid", out_valid, 0);
    check("abst_ones", ones_cnt, 5);

    // reset mid-sweep clears everything including the table
    start_sweep(8'hFF, 1'b1);
    for (int c = 0; c < 20 && out_row != 3'd4; c++) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    sb.delete();
    @(negedge clk);
    check("mrst_valid", out_valid, 0);
    check("mrst_busy", busy, 0);
    check("mrst_done", done, 0);
    check("mrst_ones", ones_cnt, 0);
    check("mrst_row", out_row, 0);
    check("mrst_s", out_s, 0);
    start_sweep(8'h00, 1'b0);
    wait_done(40, cyc);
    check("mrst_tt_cleared", ones_cnt, 0);

    // single-input instance, table 2'b10
    tick();
    b_tt_load = 1'b1;
    b_tt_data = 2'b10;
    b_start   = 1'b1;
    tick();
    b_tt_load = 1'b0;
    b_start   = 1'b0;
    @(negedge clk);
    check("n1_valid0", b_out_valid, 1);
    check("n1_row0", b_out_row, 0);
    check("n1_s0", b_out_s, 0);
    @(negedge clk);
    check("n1_row1", b_out_row, 1);
    check("n1_s1", b_out_s, 1);
    @(negedge clk);
    check("n1_done", b_done, 1);
    check("n1_busy", b_busy, 0);
    check("n1_ones", b_ones_cnt, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
